// File: rtl/instr_fetch_queue.sv
// instr_fetch_queue: in-order instruction fetch with a DEPTH-entry decode queue and redirect flush.
// Defining IFETCH_PERF_EN adds saturating stall/flush counters (perf_stall, perf_flush).
module instr_fetch_queue #(
  parameter int DEPTH  = 2,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] pc_addr,
  output logic              pc_advance,
  input  logic              flush,
  output logic              imem_req_valid,
  output logic [ADDR_W-1:0] imem_req_addr,
  input  logic              imem_req_ready,
  input  logic              imem_rsp_valid,
  input  logic [DATA_W-1:0] imem_rsp_data,
  output logic              id_valid,
  output logic [DATA_W-1:0] id_instr,
  output logic [ADDR_W-1:0] id_pc,
  output logic [ADDR_W-1:0] id_pc_plus4,
  input  logic              id_ready
`ifdef IFETCH_PERF_EN
  ,
  output logic [31:0]       perf_stall,
  output logic [15:0]       perf_flush
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam int LVL_W = CNT_W + 1;

  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  pend_wr_q, pend_wr_d;
  logic [PTR_W-1:0]  pend_rd_q, pend_rd_d;
  logic [CNT_W-1:0]  occ_q, occ_d;
  logic [CNT_W-1:0]  outst_q, outst_d;
  logic [CNT_W-1:0]  stale_q, stale_d;

  logic [ADDR_W-1:0] pend_pc_q    [DEPTH];
  logic [ADDR_W-1:0] fifo_pc_q    [DEPTH];
  logic [DATA_W-1:0] fifo_instr_q [DEPTH];

  logic              has_data;
  logic              pop;
  logic              push;
  logic              rsp_fire;
  logic              credit;
  logic              accept;
  logic [LVL_W-1:0]  level;
  logic [DEPTH-1:0]  pend_we;
  logic [DEPTH-1:0]  fifo_we;

  assign has_data = (occ_q != '0);
  assign pop      = !reset && !flush && has_data && id_ready;
  // Responses with nothing outstanding (late ones after a reset) are ignored.
  assign rsp_fire = imem_rsp_valid && (outst_q != '0);
  assign push     = rsp_fire && (stale_q == '0) && !flush;

  // Counting the same-cycle pop as freed space is what sustains one instruction per cycle.
  assign level  = LVL_W'(outst_q) + LVL_W'(occ_q) - LVL_W'(pop);
  assign credit = (level < LVL_W'(DEPTH));

  assign imem_req_valid = !reset && !flush && credit;
  assign accept         = imem_req_valid && imem_req_ready;
  assign pc_advance     = accept;
  assign imem_req_addr  = reset ? '0 : pc_addr;

  assign id_valid    = !reset && !flush && has_data;
  assign id_instr    = (!reset && has_data) ? fifo_instr_q[rd_ptr_q] : '0;
  assign id_pc       = (!reset && has_data) ? fifo_pc_q[rd_ptr_q] : '0;
  assign id_pc_plus4 = (!reset && has_data) ? fifo_pc_q[rd_ptr_q] + ADDR_W'(4) : '0;

  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    occ_d     = occ_q;
    outst_d   = outst_q;
    stale_d   = stale_q;
    pend_wr_d = pend_wr_q + PTR_W'(accept);
    pend_rd_d = pend_rd_q + PTR_W'(rsp_fire);
    if (flush) begin
      // Everything still in flight becomes stale; a response arriving now is already dropped.
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      occ_d    = '0;
      outst_d  = outst_q - CNT_W'(rsp_fire);
      stale_d  = outst_q - CNT_W'(rsp_fire);
    end else begin
      wr_ptr_d = wr_ptr_q + PTR_W'(push);
      rd_ptr_d = rd_ptr_q + PTR_W'(pop);
      occ_d    = occ_q + CNT_W'(push) - CNT_W'(pop);
      outst_d  = outst_q + CNT_W'(accept) - CNT_W'(rsp_fire);
      if (rsp_fire && (stale_q != '0)) begin
        stale_d = stale_q - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      pend_wr_q <= '0;
      pend_rd_q <= '0;
      occ_q     <= '0;
      outst_q   <= '0;
      stale_q   <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      pend_wr_q <= pend_wr_d;
      pend_rd_q <= pend_rd_d;
      occ_q     <= occ_d;
      outst_q   <= outst_d;
      stale_q   <= stale_d;
    end
  end

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_we
    assign pend_we[gi] = accept && (pend_wr_q == PTR_W'(gi));
    assign fifo_we[gi] = push && (wr_ptr_q == PTR_W'(gi));
  end

  // The pending-PC queue pairs each in-order response with the address that produced it.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (pend_we[i]) begin
        pend_pc_q[i] <= pc_addr;
      end
      if (fifo_we[i]) begin
        fifo_pc_q[i]    <= pend_pc_q[pend_rd_q];
        fifo_instr_q[i] <= imem_rsp_data;
      end
    end
  end

`ifdef IFETCH_PERF_EN
  logic [31:0] perf_stall_q, perf_stall_d;
  logic [15:0] perf_flush_q, perf_flush_d;

  always_comb begin
    perf_stall_d = perf_stall_q;
    perf_flush_d = perf_flush_q;
    if (!credit && !flush && (perf_stall_q != '1)) begin
      perf_stall_d = perf_stall_q + 32'd1;
    end
    if (flush && (perf_flush_q != '1)) begin
      perf_flush_d = perf_flush_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_stall_q <= '0;
      perf_flush_q <= '0;
    end else begin
      perf_stall_q <= perf_stall_d;
      perf_flush_q <= perf_flush_d;
    end
  end

  assign perf_stall = perf_stall_q;
  assign perf_flush = perf_flush_q;
`endif

`ifndef SYNTHESIS
  // Orphaned responses are tolerated only between a reset and the first new request.
  logic orphan_ok_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      orphan_ok_q <= 1'b1;
    end else if (accept) begin
      orphan_ok_q <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && imem_rsp_valid && (outst_q == '0)) begin
      assert (orphan_ok_q)
        else $error("instr_fetch_queue: response with no outstanding request");
    end
  end
`endif

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Bench for instr_fetch_queue: memory model with 1-cycle latency plus a scoreboard of
// expected {pc, instr, pc+4} entries compared against what decode pops.
module tb_instr_fetch_queue;
  localparam int DEPTH = 2;
  localparam int AW    = 32;
  localparam int DW    = 32;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] p4;
  } ent_t;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] pc_addr;
  logic          pc_advance;
  logic          flush;
  logic          imem_req_valid;
  logic [AW-1:0] imem_req_addr;
  logic          imem_req_ready;
  logic          imem_rsp_valid;
  logic [DW-1:0] imem_rsp_data;
  logic          id_valid;
  logic [DW-1:0] id_instr;
  logic [AW-1:0] id_pc;
  logic [AW-1:0] id_pc_plus4;
  logic          id_ready;
`ifdef IFETCH_PERF_EN
  logic [31:0]   perf_stall;
  logic [15:0]   perf_flush;
`endif

  always #5 clk = ~clk;

  instr_fetch_queue #(.DEPTH(DEPTH), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk            (clk),
    .reset          (reset),
    .pc_addr        (pc_addr),
    .pc_advance     (pc_advance),
    .flush          (flush),
    .imem_req_valid (imem_req_valid),
    .imem_req_addr  (imem_req_addr),
    .imem_req_ready (imem_req_ready),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .id_valid       (id_valid),
    .id_instr       (id_instr),
    .id_pc          (id_pc),
    .id_pc_plus4    (id_pc_plus4),
    .id_ready       (id_ready)
`ifdef IFETCH_PERF_EN
    ,
    .perf_stall     (perf_stall),
    .perf_flush     (perf_flush)
`endif
  );

  int          errors = 0;
  int          checks = 0;
  int          cyc_n  = 0;
  int          acc_n  = 0;
  logic        rsp_hold = 1'b0;
  logic [31:0] cur_pc = '0;
  logic        obs_rv, obs_adv, obs_idv;
  logic [31:0] mem_q[$];
  ent_t        exp_q[$];
  ent_t        got_q[$];
  int          got_cyc[$];

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return (a * 32'd2654435761) ^ 32'h0BAD_F00D;
  endfunction

  function automatic ent_t mk(input logic [31:0] pc);
    ent_t e;
    e.pc    = pc;
    e.instr = instr_of(pc);
    e.p4    = pc + 32'd4;
    return e;
  endfunction

  // One clock: memory answers the oldest accepted request, PC register advances on accept.
  task automatic cyc(input logic fl, input logic rr, input logic idr);
    ent_t g;
    flush          = fl;
    imem_req_ready = rr;
    id_ready       = idr;
    pc_addr        = cur_pc;
    if (!rsp_hold && mem_q.size() > 0) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = instr_of(mem_q.pop_front());
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
    end
    #1;
    obs_rv  = imem_req_valid;
    obs_adv = pc_advance;
    obs_idv = id_valid;
    if (pc_advance) begin
      mem_q.push_back(imem_req_addr);
      cur_pc = cur_pc + 32'd4;
      acc_n++;
    end
    if (id_valid && id_ready) begin
      g.pc = id_pc; g.instr = id_instr; g.p4 = id_pc_plus4;
      got_q.push_back(g);
      got_cyc.push_back(cyc_n);
      $display("pop cycle=%0d pc=%08h instr=%08h pc4=%08h", cyc_n, g.pc, g.instr, g.p4);
    end
    @(posedge clk);
    #1;
    cyc_n++;
  endtask

  task automatic clear_sb(input logic [31:0] pc);
    exp_q.delete(); got_q.delete(); got_cyc.delete();
    cur_pc = pc;
    acc_n  = 0;
  endtask

  task automatic test_reset;
    pc_addr = 32'h1234; imem_req_ready = 1'b1; id_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL reset_req_valid: got %b expected 0", imem_req_valid); end
    checks++; if (pc_advance !== 1'b0) begin errors++; $display("FAIL reset_pc_advance: got %b expected 0", pc_advance); end
    checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL reset_id_valid: got %b expected 0", id_valid); end
    checks++; if (imem_req_addr !== 32'h0) begin errors++; $display("FAIL reset_req_addr: got %h expected 0", imem_req_addr); end
    checks++; if (id_pc_plus4 !== 32'h0) begin errors++; $display("FAIL reset_pc_plus4: got %h expected 0", id_pc_plus4); end
    imem_req_ready = 1'b0;
    reset = 1'b0;
    #1;
    checks++; if (imem_req_valid !== 1'b1) begin errors++; $display("FAIL post_reset_req_valid: got %b expected 1", imem_req_valid); end
    checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL post_reset_id_valid: got %b expected 0", id_valid); end
  endtask

  task automatic test_stream;
    ent_t e, g;
    clear_sb(32'h0);
    for (int i = 0; i < 6; i++) exp_q.push_back(mk(32'(i * 4)));
    for (int i = 0; i < 40 && got_q.size() < 6; i++) cyc(1'b0, acc_n < 6, 1'b1);
    checks++; if (got_q.size() != 6) begin errors++; $display("FAIL stream_count: got %0d expected 6", got_q.size()); end
    for (int i = 1; i < got_cyc.size(); i++) begin
      checks++; if (got_cyc[i] - got_cyc[i-1] != 1) begin errors++; $display("FAIL stream_throughput: gap %0d expected 1", got_cyc[i] - got_cyc[i-1]); end
    end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      checks++; if (g.pc !== e.pc) begin errors++; $display("FAIL stream_pc: got %h expected %h", g.pc, e.pc); end
      checks++; if (g.instr !== e.instr) begin errors++; $display("FAIL stream_instr: got %h expected %h", g.instr, e.instr); end
      checks++; if (g.p4 !== e.p4) begin errors++; $display("FAIL stream_pc_plus4: got %h expected %h", g.p4, e.p4); end
    end
  endtask

  task automatic test_backpressure;
    ent_t e, g;
    clear_sb(32'h40);
    for (int i = 0; i < 4; i++) exp_q.push_back(mk(32'h40 + 32'(i * 4)));
    repeat (6) cyc(1'b0, 1'b1, 1'b0);
    checks++; if (acc_n != 2) begin errors++; $display("FAIL bp_accepts: got %0d expected 2", acc_n); end
    checks++; if (obs_rv !== 1'b0) begin errors++; $display("FAIL bp_req_valid: got %b expected 0", obs_rv); end
    checks++; if (obs_adv !== 1'b0) begin errors++; $display("FAIL bp_pc_advance: got %b expected 0", obs_adv); end
    checks++; if (id_pc !== 32'h40) begin errors++; $display("FAIL bp_head_hold: got %h expected 00000040", id_pc); end
    cyc(1'b0, 1'b1, 1'b1);
    checks++; if (obs_adv !== 1'b1) begin errors++; $display("FAIL bp_resume: got %b expected 1", obs_adv); end
    for (int i = 0; i < 40 && got_q.size() < 4; i++) cyc(1'b0, acc_n < 4, 1'b1);
    checks++; if (got_q.size() != 4) begin errors++; $display("FAIL bp_count: got %0d expected 4", got_q.size()); end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      checks++; if (g.pc !== e.pc) begin errors++; $display("FAIL bp_pc: got %h expected %h", g.pc, e.pc); end
      checks++; if (g.instr !== e.instr) begin errors++; $display("FAIL bp_instr: got %h expected %h", g.instr, e.instr); end
    end
  endtask

  task automatic test_flush_inflight;
    ent_t e, g;
    clear_sb(32'h200);
    rsp_hold = 1'b0;
    cyc(1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b0);
    rsp_hold = 1'b1;
    checks++; if (id_valid !== 1'b1) begin errors++; $display("FAIL fl_buffered: got %b expected 1", id_valid); end
    cyc(1'b1, 1'b1, 1'b1);
    checks++; if (obs_idv !== 1'b0) begin errors++; $display("FAIL fl_id_valid: got %b expected 0", obs_idv); end
    checks++; if (obs_rv !== 1'b0) begin errors++; $display("FAIL fl_req_valid: got %b expected 0", obs_rv); end
    checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL fl_cleared: got %b expected 0", id_valid); end
    cur_pc = 32'h100;
    rsp_hold = 1'b0;
    exp_q.push_back(mk(32'h100));
    for (int i = 0; i < 20 && got_q.size() < 1; i++) cyc(1'b0, acc_n < 3, 1'b1);
    repeat (3) cyc(1'b0, 1'b0, 1'b1);
    checks++; if (got_q.size() != 1) begin errors++; $display("FAIL fl_count: got %0d expected 1", got_q.size()); end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      checks++; if (g.pc !== e.pc) begin errors++; $display("FAIL fl_pc: got %h expected %h", g.pc, e.pc); end
      checks++; if (g.instr !== e.instr) begin errors++; $display("FAIL fl_instr: got %h expected %h", g.instr, e.instr); end
    end
  endtask

  task automatic test_flush_same;
    ent_t e, g;
    clear_sb(32'h300);
    rsp_hold = 1'b1;
    cyc(1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b0);
    checks++; if (acc_n != 2) begin errors++; $display("FAIL fs_accepts: got %0d expected 2", acc_n); end
    rsp_hold = 1'b0;
    cyc(1'b1, 1'b1, 1'b1);
    checks++; if (obs_idv !== 1'b0) begin errors++; $display("FAIL fs_no_pop: got %b expected 0", obs_idv); end
    checks++; if (obs_adv !== 1'b0) begin errors++; $display("FAIL fs_pc_advance: got %b expected 0", obs_adv); end
    cur_pc = 32'h180;
    exp_q.push_back(mk(32'h180));
    for (int i = 0; i < 20 && got_q.size() < 1; i++) cyc(1'b0, acc_n < 3, 1'b1);
    repeat (3) cyc(1'b0, 1'b0, 1'b1);
    checks++; if (got_q.size() != 1) begin errors++; $display("FAIL fs_count: got %0d expected 1", got_q.size()); end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      checks++; if (g.pc !== e.pc) begin errors++; $display("FAIL fs_pc: got %h expected %h", g.pc, e.pc); end
      checks++; if (g.instr !== e.instr) begin errors++; $display("FAIL fs_instr: got %h expected %h", g.instr, e.instr); end
    end
  endtask

  task automatic test_wrap;
    ent_t e, g;
    clear_sb(32'hFFFF_FFFC);
    exp_q.push_back(mk(32'hFFFF_FFFC));
    exp_q.push_back(mk(32'h0000_0000));
    for (int i = 0; i < 20 && got_q.size() < 2; i++) cyc(1'b0, acc_n < 2, 1'b1);
    checks++; if (got_q.size() != 2) begin errors++; $display("FAIL wrap_count: got %0d expected 2", got_q.size()); end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      checks++; if (g.pc !== e.pc) begin errors++; $display("FAIL wrap_pc: got %h expected %h", g.pc, e.pc); end
      checks++; if (g.p4 !== e.p4) begin errors++; $display("FAIL wrap_pc_plus4: got %h expected %h", g.p4, e.p4); end
    end
  endtask

  task automatic test_reset_mid;
    ent_t e, g;
    clear_sb(32'h600);
    rsp_hold = 1'b1;
    cyc(1'b0, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b0);
    imem_req_ready = 1'b1; id_ready = 1'b1;
    #2;
    reset = 1'b1;
    #1;
    checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL rm_req_valid: got %b expected 0", imem_req_valid); end
    checks++; if (pc_advance !== 1'b0) begin errors++; $display("FAIL rm_pc_advance: got %b expected 0", pc_advance); end
    checks++; if (imem_req_addr !== 32'h0) begin errors++; $display("FAIL rm_req_addr: got %h expected 0", imem_req_addr); end
    @(posedge clk);
    #1;
    reset = 1'b0;
    rsp_hold = 1'b0;
    repeat (4) cyc(1'b0, 1'b0, 1'b1);
    checks++; if (got_q.size() != 0) begin errors++; $display("FAIL rm_late_stored: got %0d expected 0", got_q.size()); end
    checks++; if (id_valid !== 1'b0) begin errors++; $display("FAIL rm_id_valid: got %b expected 0", id_valid); end
    clear_sb(32'h500);
    exp_q.push_back(mk(32'h500));
    exp_q.push_back(mk(32'h504));
    for (int i = 0; i < 20 && got_q.size() < 2; i++) cyc(1'b0, acc_n < 2, 1'b1);
    checks++; if (got_q.size() != 2) begin errors++; $display("FAIL rm_count: got %0d expected 2", got_q.size()); end
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      e = exp_q.pop_front(); g = got_q.pop_front();
      checks++; if (g.pc !== e.pc) begin errors++; $display("FAIL rm_pc: got %h expected %h", g.pc, e.pc); end
      checks++; if (g.instr !== e.instr) begin errors++; $display("FAIL rm_instr: got %h expected %h", g.instr, e.instr); end
    end
  endtask

`ifdef IFETCH_PERF_EN
  task automatic test_perf;
    flush = 1'b0; imem_req_ready = 1'b0; id_ready = 1'b0; imem_rsp_valid = 1'b0;
    #2;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    mem_q.delete();
    clear_sb(32'h700);
    rsp_hold = 1'b1;
    repeat (7) cyc(1'b0, 1'b1, 1'b0);
    repeat (2) cyc(1'b1, 1'b1, 1'b0);
    checks++; if (perf_stall !== 32'd5) begin errors++; $display("FAIL perf_stall: got %0d expected 5", perf_stall); end
    checks++; if (perf_flush !== 16'd2) begin errors++; $display("FAIL perf_flush: got %0d expected 2", perf_flush); end
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog: time limit reached, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; pc_addr = '0; flush = 1'b0; imem_req_ready = 1'b0;
    imem_rsp_valid = 1'b0; imem_rsp_data = '0; id_ready = 1'b0;
    test_reset;
    test_stream;
    test_backpressure;
    test_flush_inflight;
    test_flush_same;
    test_wrap;
    test_reset_mid;
`ifdef IFETCH_PERF_EN
    test_perf;
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
